// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the two-port register bank arbiter.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef logic req_idx_t;

  // The address MSB selects the read-only status region.
  function automatic logic is_status_addr(input logic [31:0] addr, input int addr_w);
    return addr[addr_w-1];
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick with an optional hold for the last-served requester.
module rr_arbiter_2
  import reg_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_idx_t   last,
  input  logic       lock_hold,
  output logic       gnt_valid,
  output req_idx_t   gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    if (lock_hold && req[last]) begin
      gnt_idx = last;
    end else if (&req) begin
      gnt_idx = ~last;
    end else begin
      gnt_idx = req[1];
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Shares one config/status register bank between two requesters, one
// registered access per grant: IDLE (arbitrate) -> ACCESS (bank strobe) -> RESP (ack).
module reg_bank_arbiter
  import reg_arb_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int REG_W     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_lock,
  input  logic              m0_wr_rdn,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [REG_W-1:0]  m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [REG_W-1:0]  m0_rdata,
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic              m1_wr_rdn,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [REG_W-1:0]  m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [REG_W-1:0]  m1_rdata,
  output logic              bk_en,
  output logic              bk_we,
  output logic [ADDR_W-1:0] bk_addr,
  output logic [REG_W-1:0]  bk_wdata,
  input  logic [REG_W-1:0]  bk_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  // Handshake: a requester holds req and its fields stable until its ack
  // pulse; it must drop req or present a new access in the following cycle.
  state_t            state;
  state_t            state_next;
  req_idx_t          owner;
  req_idx_t          last;
  logic              last_lock;
  logic [CNT_W-1:0]  burst_cnt;
  logic              lat_wr;
  logic              lat_lock;
  logic [ADDR_W-1:0] lat_addr;
  logic [REG_W-1:0]  lat_wdata;
  logic              err_q;
  logic [REG_W-1:0]  rdata0;
  logic [REG_W-1:0]  rdata1;

  logic              gnt_valid;
  req_idx_t          gnt_idx;
  logic              lock_hold;
  logic              access_cyc;
  logic              resp_cyc;
  logic              lat_status;

  assign lock_hold  = last_lock && (burst_cnt < CNT_W'(MAX_BURST));
  assign lat_status = is_status_addr(32'(lat_addr), ADDR_W);

  rr_arbiter_2 u_rr (
    .req       ({m1_req, m0_req}),
    .last      (last),
    .lock_hold (lock_hold),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (gnt_valid) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      last_lock <= 1'b0;
      burst_cnt <= '0;
      lat_wr    <= 1'b0;
      lat_lock  <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      err_q     <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            owner     <= gnt_idx;
            lat_wr    <= gnt_idx ? m1_wr_rdn : m0_wr_rdn;
            lat_lock  <= gnt_idx ? m1_lock   : m0_lock;
            lat_addr  <= gnt_idx ? m1_addr   : m0_addr;
            lat_wdata <= gnt_idx ? m1_wdata  : m0_wdata;
            err_q     <= 1'b0;
          end
        end
        ACCESS: begin
          if (!lat_wr) begin
            if (owner) rdata1 <= bk_rdata;
            else       rdata0 <= bk_rdata;
          end else if (lat_status) begin
            err_q <= 1'b1;
          end
        end
        RESP: begin
          last      <= owner;
          last_lock <= lat_lock;
          // A locked grant after an owner change is the first of a new burst.
          if (!lat_lock)                             burst_cnt <= '0;
          else if (owner != last)                    burst_cnt <= CNT_W'(1);
          else if (burst_cnt < CNT_W'(MAX_BURST))    burst_cnt <= burst_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Gating with rst aborts an in-flight access in the same cycle.
  assign access_cyc = (state == ACCESS) && !rst;
  assign resp_cyc   = (state == RESP) && !rst;

  assign bk_en    = access_cyc;
  assign bk_we    = access_cyc && lat_wr && !lat_status;
  assign bk_addr  = access_cyc ? lat_addr  : '0;
  assign bk_wdata = access_cyc ? lat_wdata : '0;

  assign m0_ack   = resp_cyc && (owner == 1'b0);
  assign m1_ack   = resp_cyc && (owner == 1'b1);
  assign m0_err   = m0_ack && err_q;
  assign m1_err   = m1_ack && err_q;
  assign m0_rdata = rdata0;
  assign m1_rdata = rdata1;

endmodule
